pspin_hostmem_rd_arb: RTL and testbench
=======================================

PSPIN_HOSTMEM_RD_ARB -- requirements
Module: pspin_hostmem_rd_arb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NUM_PORTS, 4, number of AXI read requesters; ADDR_WIDTH, 64, AXI address width; DATA_WIDTH, 512, R data width; ID_WIDTH, 8, AXI ID width; RUSER_WIDTH, 1, R user width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), with clock and reset listed first:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_axi_arid  in  NUM_PORTS*ID_WIDTH  per-port ARID.
- s_axi_araddr  in  NUM_PORTS*ADDR_WIDTH  per-port ARADDR.
- s_axi_arlen  in  NUM_PORTS*8  per-port ARLEN.
- s_axi_arsize  in  NUM_PORTS*3  per-port ARSIZE.
- s_axi_arburst  in  NUM_PORTS*2  per-port ARBURST.
- s_axi_arvalid  in  NUM_PORTS  per-port ARVALID.
- s_axi_arready  out  NUM_PORTS  per-port ARREADY.
- s_axi_rid  out  NUM_PORTS*ID_WIDTH  per-port RID.
- s_axi_rdata  out  NUM_PORTS*DATA_WIDTH  per-port RDATA.
- s_axi_rresp  out  NUM_PORTS*2  per-port RRESP.
- s_axi_rlast  out  NUM_PORTS  per-port RLAST.
- s_axi_ruser  out  NUM_PORTS*RUSER_WIDTH  per-port RUSER.
- s_axi_rvalid  out  NUM_PORTS  per-port RVALID.
- s_axi_rready  in  NUM_PORTS  per-port RREADY.
- m_axi_ar{id,addr,len,size,burst,valid}  out  matching widths  AR channel to the hostmem DMA read datapath.
- m_axi_arready  in  1  datapath ARREADY.
- m_axi_r{id,data,resp,last,user,valid}  in  matching widths  R channel from the datapath.
- m_axi_rready  out  1  datapath RREADY.
- busy  out  1  a transaction is in flight.
- grant_idx  out  $clog2(NUM_PORTS)  current or last granted port.

Function
REQ-003 The block SHALL have exactly one transaction in flight, because the downstream datapath is single-transaction.
REQ-004 The block SHALL implement three states: IDLE, ISSUE and DATA.
REQ-005 In IDLE, the block SHALL select a winner combinationally, round-robin, as the first port with arvalid set, searching from rr_ptr upward with wrap at NUM_PORTS-1 back to 0.
REQ-006 In IDLE, the block SHALL assert s_axi_arready only for the winner, and only while that winner's arvalid is 1; all other arready bits SHALL be 0.
REQ-007 On the winner's AR handshake, the block SHALL register the AR fields and the grant index, and move IDLE to ISSUE.
REQ-008 In ISSUE, m_axi_arvalid SHALL be 1 with the registered fields, first driven one cycle after the AR handshake; on m_axi_arvalid && m_axi_arready the block SHALL move ISSUE to DATA.
REQ-009 In DATA, the block SHALL forward R combinationally to the granted port:
- s_axi_rvalid[g] = m_axi_rvalid.
- m_axi_rready = s_axi_rready[g].
- rid, rdata, rresp, rlast and ruser are passed unchanged.
- rvalid for all other ports is 0.
REQ-010 s_axi_r{id,data,resp,last,user} SHALL be driven from the m_axi_r* signals on all port slices; rvalid SHALL qualify them.
REQ-011 On m_axi_rvalid && m_axi_rready && m_axi_rlast in DATA, the block SHALL move to IDLE and set rr_ptr = (g+1) mod NUM_PORTS.
REQ-012 A new grant SHALL be possible at the earliest on the cycle after the last R handshake (IDLE cycle).
REQ-013 m_axi_rready SHALL be 0 outside DATA; any R beat presented outside DATA SHALL be held off, not dropped.
REQ-014 rresp SHALL be passed through unchanged, including SLVERR; an error SHALL NOT end the transaction early, and the block SHALL wait for rlast.
REQ-015 busy SHALL be 1 in ISSUE and DATA.
REQ-016 grant_idx SHALL hold the registered grant index.
REQ-017 If requests arrive simultaneously, only one port SHALL be granted per IDLE cycle; losers SHALL keep arvalid asserted, per AXI rules.
REQ-018 If a requester's arvalid drops while it is the winner (protocol violation), the block SHALL perform no handshake and re-arbitrate in the next cycle.
REQ-019 rr_ptr SHALL update only on transaction completion, so a port that is winning but stalled keeps its priority.

Reset
REQ-020 While rstn=0, the block SHALL set:
- state to IDLE.
- rr_ptr to 0.
- grant_idx to 0.
- all registered AR fields to 0.
- m_axi_arvalid, m_axi_rready and all s_axi_arready / s_axi_rvalid to 0.
- busy to 0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction without draining; the datapath is reset by the same rstn.

Structure
REQ-022 State encodings and the AXI response constants SHALL live in the shared pspin hostmem package, alongside those of the read datapath.
REQ-023 The round-robin winner search SHALL be a sub-module, pspin_rr_arb_comb, with inputs req and ptr and outputs valid and idx, so that the write-side arbiter can reuse it.

Verification
REQ-024 Single request: port 2 issues arlen=3 with m_axi_arready=1. Required: m_axi_arvalid rises 1 cycle after the AR handshake; 4 beats are seen on port 2 only, with rlast on beat 4; busy falls the cycle after.
REQ-025 Simultaneous requests: all 4 ports have arvalid from reset. Required: grants in order 0,1,2,3,0; no port has a second AR accepted until all others have been served.
REQ-026 Backpressure: granted port 1 holds rready=0 for 5 cycles mid-burst. Required: m_axi_rready=0 for those cycles; no beat is lost or duplicated; rdata and rid are stable while rvalid=1.
REQ-027 Error response: the datapath returns SLVERR on all 2 beats of arlen=1. Required: both beats reach the requester with rresp=2'b10 and rlast on beat 2; the arbiter then returns to IDLE.
REQ-028 Reset mid-DATA: rstn=0 for 1 cycle after 2 of 8 beats. Required: all outputs take their reset values; the next request from port 0 is granted normally.
REQ-029 AR stall: m_axi_arready=0 for 10 cycles. Required: m_axi_arvalid and the AR fields are held stable; s_axi_arready is 0 for every port throughout.

Source files
------------

// File: rtl/pspin_hostmem_pkg.sv
// Shared encodings for the pspin hostmem DMA read path: arbiter and datapath FSM states, AXI responses.
// Lives beside the read datapath so both sides agree on the numeric values.
package pspin_hostmem_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_DATA  = 2'd2;

  localparam logic [1:0] DP_IDLE  = 2'd0;
  localparam logic [1:0] DP_BURST = 2'd1;
  localparam logic [1:0] DP_RESP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Round-robin successor of a port index, wrapping at n-1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pspin_rr_arb_comb.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping to 0.
// Zero latency; no flow control of its own, the caller decides when a pick is consumed.
module pspin_rr_arb_comb #(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int unsigned p;
      p = (32'(ptr_i) + 32'(i)) % NUM_PORTS;
      if (!valid_o && req_i[p]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/pspin_hostmem_rd_arb.sv
// N:1 AXI read arbiter in front of the single-transaction hostmem read datapath; AR reaches the
// datapath one cycle after the winning handshake, R is forwarded combinationally and RREADY follows the granted port.
module pspin_hostmem_rd_arb
  import pspin_hostmem_pkg::*;
#(
  parameter  int NUM_PORTS   = 4,
  parameter  int ADDR_WIDTH  = 64,
  parameter  int DATA_WIDTH  = 512,
  parameter  int ID_WIDTH    = 8,
  parameter  int RUSER_WIDTH = 1,
  localparam int IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              rstn,

  input  logic [NUM_PORTS*ID_WIDTH-1:0]     s_axi_arid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [NUM_PORTS*8-1:0]            s_axi_arlen,
  input  logic [NUM_PORTS*3-1:0]            s_axi_arsize,
  input  logic [NUM_PORTS*2-1:0]            s_axi_arburst,
  input  logic [NUM_PORTS-1:0]              s_axi_arvalid,
  output logic [NUM_PORTS-1:0]              s_axi_arready,

  output logic [NUM_PORTS*ID_WIDTH-1:0]     s_axi_rid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [NUM_PORTS*2-1:0]            s_axi_rresp,
  output logic [NUM_PORTS-1:0]              s_axi_rlast,
  output logic [NUM_PORTS*RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic [NUM_PORTS-1:0]              s_axi_rvalid,
  input  logic [NUM_PORTS-1:0]              s_axi_rready,

  output logic [ID_WIDTH-1:0]               m_axi_arid,
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic [7:0]                        m_axi_arlen,
  output logic [2:0]                        m_axi_arsize,
  output logic [1:0]                        m_axi_arburst,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,

  input  logic [ID_WIDTH-1:0]               m_axi_rid,
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]            m_axi_ruser,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready,

  output logic                              busy,
  output logic [IDX_W-1:0]                  grant_idx
);

  logic [1:0]            state_q,  state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q,  grant_d;
  logic [ID_WIDTH-1:0]   arid_q,   arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q,  arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;

  logic             arb_vld;
  logic [IDX_W-1:0] arb_idx;
  int               win;
  logic             in_idle, in_issue, in_data;

  pspin_rr_arb_comb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arb (
    .req_i   (s_axi_arvalid),
    .ptr_i   (rr_ptr_q),
    .valid_o (arb_vld),
    .idx_o   (arb_idx)
  );

  // Outputs are gated with rstn so reset values appear while rstn is low, not one edge later.
  assign in_idle  = rstn && (state_q == ARB_IDLE);
  assign in_issue = rstn && (state_q == ARB_ISSUE);
  assign in_data  = rstn && (state_q == ARB_DATA);
  assign win      = int'(arb_idx);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_vld) begin
          state_d   = ARB_ISSUE;
          grant_d   = arb_idx;
          arid_d    = s_axi_arid[win*ID_WIDTH +: ID_WIDTH];
          araddr_d  = s_axi_araddr[win*ADDR_WIDTH +: ADDR_WIDTH];
          arlen_d   = s_axi_arlen[win*8 +: 8];
          arsize_d  = s_axi_arsize[win*3 +: 3];
          arburst_d = s_axi_arburst[win*2 +: 2];
        end
      end
      ARB_ISSUE: begin
        if (m_axi_arready) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        // Only rlast ends the burst; error responses are just forwarded.
        if (m_axi_rvalid && s_axi_rready[grant_q] && m_axi_rlast) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IDX_W'(rr_next(32'(grant_q), NUM_PORTS));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

  always_comb begin
    s_axi_arready = '0;
    if (in_idle && arb_vld) s_axi_arready[arb_idx] = 1'b1;
  end

  always_comb begin
    s_axi_rvalid = '0;
    if (in_data) s_axi_rvalid[grant_q] = m_axi_rvalid;
  end

  assign m_axi_rready  = in_data && s_axi_rready[grant_q];

  assign m_axi_arvalid = in_issue;
  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = arsize_q;
  assign m_axi_arburst = arburst_q;

  assign s_axi_rid     = {NUM_PORTS{m_axi_rid}};
  assign s_axi_rdata   = {NUM_PORTS{m_axi_rdata}};
  assign s_axi_rresp   = {NUM_PORTS{m_axi_rresp}};
  assign s_axi_rlast   = {NUM_PORTS{m_axi_rlast}};
  assign s_axi_ruser   = {NUM_PORTS{m_axi_ruser}};

  assign busy      = in_issue || in_data;
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_pspin_hostmem_rd_arb.sv
// Directed + randomized bench for pspin_hostmem_rd_arb; the bench plays both the requesters and the read datapath.
module tb_pspin_hostmem_rd_arb;
  localparam int NP = 4, AW = 64, DW = 512, IW = 8, UW = 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic [NP*IW-1:0] s_axi_arid;
  logic [NP*AW-1:0] s_axi_araddr;
  logic [NP*8-1:0]  s_axi_arlen;
  logic [NP*3-1:0]  s_axi_arsize;
  logic [NP*2-1:0]  s_axi_arburst;
  logic [NP-1:0]    s_axi_arvalid;
  logic [NP-1:0]    s_axi_arready;
  logic [NP*IW-1:0] s_axi_rid;
  logic [NP*DW-1:0] s_axi_rdata;
  logic [NP*2-1:0]  s_axi_rresp;
  logic [NP-1:0]    s_axi_rlast;
  logic [NP*UW-1:0] s_axi_ruser;
  logic [NP-1:0]    s_axi_rvalid;
  logic [NP-1:0]    s_axi_rready;
  logic [IW-1:0]    m_axi_arid;
  logic [AW-1:0]    m_axi_araddr;
  logic [7:0]       m_axi_arlen;
  logic [2:0]       m_axi_arsize;
  logic [1:0]       m_axi_arburst;
  logic             m_axi_arvalid;
  logic             m_axi_arready;
  logic [IW-1:0]    m_axi_rid;
  logic [DW-1:0]    m_axi_rdata;
  logic [1:0]       m_axi_rresp;
  logic             m_axi_rlast;
  logic [UW-1:0]    m_axi_ruser;
  logic             m_axi_rvalid;
  logic             m_axi_rready;
  logic             busy;
  logic [1:0]       grant_idx;

  int nchk = 0;
  int nerr = 0;
  int ptr_m = 0;
  logic [IW-1:0] q_id[NP];
  logic [AW-1:0] q_addr[NP];
  logic [7:0]    q_len[NP];

  always #5 clk = ~clk;

  pspin_hostmem_rd_arb dut (
    .clk(clk), .rstn(rstn),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .busy(busy), .grant_idx(grant_idx)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference arbitration: first requesting port at or after the pointer, cyclically.
  function automatic int model_winner();
    for (int i = 0; i < NP; i++)
      if (s_axi_arvalid[(ptr_m + i) % NP]) return (ptr_m + i) % NP;
    return -1;
  endfunction

  task automatic issue(input int p, input int len);
    q_id[p]   = 8'($urandom);
    q_addr[p] = {$urandom, $urandom};
    q_len[p]  = 8'(len);
    s_axi_arid[p*IW +: IW]   = q_id[p];
    s_axi_araddr[p*AW +: AW] = q_addr[p];
    s_axi_arlen[p*8 +: 8]    = q_len[p];
    s_axi_arsize[p*3 +: 3]   = 3'd6;
    s_axi_arburst[p*2 +: 2]  = 2'b01;
    s_axi_arvalid[p]         = 1'b1;
  endtask

  // One complete transaction: grant, AR issue (optionally stalled), R burst (optionally stalled),
  // or an early reset after rst_after beats.
  task automatic serve(input int arstall, input int rstall, input int stall_beat,
                       input logic [1:0] resp, input int reissue_len, input int rst_after,
                       output int win);
    int ew, b, st, guard, elen;
    logic [IW-1:0] eid;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    bit hs;
    ew = model_winner();
    win = ew;
    if (ew < 0) return;
    guard = 0;
    #1;
    while (s_axi_arready == '0 && guard < 4) begin cyc(); #1; guard++; end
    chk("grant_latency", guard, 0);
    chk("grant_onehot", s_axi_arready, NP'(1) << ew);
    chk("arvalid_pre", m_axi_arvalid, 0);
    eid = q_id[ew]; eaddr = q_addr[ew]; elen = int'(q_len[ew]);
    cyc();
    if (reissue_len >= 0) issue(ew, reissue_len); else s_axi_arvalid[ew] = 1'b0;
    d = rnd_data(); u = UW'($urandom);
    m_axi_rvalid = 1'b1; m_axi_rdata = d; m_axi_rid = eid; m_axi_rresp = resp;
    m_axi_rlast = (elen == 0); m_axi_ruser = u; m_axi_arready = 1'b0;
    #1;
    chk("ar_valid", m_axi_arvalid, 1);
    chk("ar_addr", m_axi_araddr, eaddr);
    chk("ar_id", m_axi_arid, eid);
    chk("ar_len", m_axi_arlen, elen);
    chk("ar_size", m_axi_arsize, 3'd6);
    chk("ar_burst", m_axi_arburst, 2'b01);
    chk("busy_issue", busy, 1);
    chk("grant_idx", grant_idx, ew);
    chk("arready_issue", s_axi_arready, 0);
    chk("r_held_issue", m_axi_rready, 0);
    chk("rvalid_issue", s_axi_rvalid, 0);
    for (int k = 0; k < arstall; k++) begin
      cyc();
      chk("arstall_vld", m_axi_arvalid, 1);
      chk("arstall_addr", m_axi_araddr, eaddr);
      chk("arstall_id", m_axi_arid, eid);
      chk("arstall_arready", s_axi_arready, 0);
    end
    m_axi_arready = 1'b1;
    cyc();
    m_axi_arready = 1'b0;
    b = 0; st = 0; guard = 0;
    while (b <= elen && guard < 300) begin
      guard++;
      if (rst_after >= 0 && b == rst_after) begin
        rstn = 1'b0;
        #1;
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_mrready", m_axi_rready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_arready", s_axi_arready, 0);
        cyc();
        chk("rst_grant", grant_idx, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arid", m_axi_arid, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        rstn = 1'b1; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_rready = '0; ptr_m = 0;
        #1;
        chk("rst_idle_busy", busy, 0);
        return;
      end
      s_axi_rready[ew] = !(b == stall_beat && st < rstall);
      #1;
      chk("rvalid_onehot", s_axi_rvalid, NP'(1) << ew);
      chk("m_rready", m_axi_rready, s_axi_rready[ew]);
      chk("rdata", s_axi_rdata[ew*DW +: DW], d);
      chk("rdata_bcast", s_axi_rdata[((ew + 1) % NP)*DW +: DW], d);
      chk("rid", s_axi_rid[ew*IW +: IW], eid);
      chk("rresp", s_axi_rresp[ew*2 +: 2], resp);
      chk("rlast", s_axi_rlast[ew], b == elen);
      chk("ruser", s_axi_ruser[ew*UW +: UW], u);
      hs = s_axi_rready[ew];
      cyc();
      if (hs) begin
        b++;
        d = rnd_data(); u = UW'($urandom);
        m_axi_rdata = d; m_axi_ruser = u; m_axi_rlast = (b == elen);
      end else begin
        st++;
      end
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_rready[ew] = 1'b0;
    chk("beats", b, elen + 1);
    #1;
    chk("busy_done", busy, 0);
    chk("m_rready_idle", m_axi_rready, 0);
    chk("rvalid_idle", s_axi_rvalid, 0);
    ptr_m = (ew + 1) % NP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, guard;
    int exp_order[9];
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = '0; s_axi_rready = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_ruser = '0; m_axi_rvalid = 1'b0;
    rstn = 1'b0;
    for (int p = 0; p < NP; p++) issue(p, $urandom_range(0, 3));
    cyc(); cyc();
    chk("reset_arready", s_axi_arready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_arvalid", m_axi_arvalid, 0);
    chk("reset_mrready", m_axi_rready, 0);
    chk("reset_rvalid", s_axi_rvalid, 0);
    chk("reset_grant", grant_idx, 0);
    chk("reset_araddr", m_axi_araddr, 0);
    rstn = 1'b1;

    // All four ports requesting from reset: five rounds with re-requests, then drain.
    for (int i = 0; i < 9; i++) begin
      serve(0, 0, -1, 2'b00, (i < 5) ? $urandom_range(0, 3) : -1, -1, w);
      chk("rr_order", grant_idx, exp_order[i]);
    end

    issue(2, 3);
    serve(0, 0, -1, 2'b00, -1, -1, w);
    chk("single_port2", grant_idx, 2);

    issue(1, 5);
    serve(0, 5, 2, 2'b00, -1, -1, w);
    chk("bp_port1", grant_idx, 1);

    issue(3, 1);
    serve(0, 0, -1, 2'b10, -1, -1, w);
    chk("slverr_port3", grant_idx, 3);

    issue(0, 2);
    issue(3, 0);
    serve(10, 0, -1, 2'b00, -1, -1, w);
    chk("arstall_port0", grant_idx, 0);
    serve(0, 0, -1, 2'b00, -1, -1, w);
    chk("after_stall_port3", grant_idx, 3);

    // A winner that withdraws arvalid before the edge gets no handshake.
    issue(2, 0);
    #1;
    chk("withdraw_arready", s_axi_arready, 4'b0100);
    s_axi_arvalid[2] = 1'b0;
    #1;
    chk("withdraw_arready_gone", s_axi_arready, 0);
    cyc();
    chk("withdraw_busy", busy, 0);
    chk("withdraw_arvalid", m_axi_arvalid, 0);

    issue(1, 7);
    serve(0, 0, -1, 2'b00, -1, 2, w);
    issue(0, 1);
    serve(0, 0, -1, 2'b00, -1, -1, w);
    chk("post_reset_port0", grant_idx, 0);

    for (int it = 0; it < 8; it++) begin
      for (int p = 0; p < NP; p++)
        if (!s_axi_arvalid[p] && $urandom_range(0, 1) == 1) issue(p, $urandom_range(0, 5));
      if (s_axi_arvalid == '0) issue($urandom_range(0, NP - 1), $urandom_range(0, 5));
      serve($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00, -1, -1, w);
    end
    guard = 0;
    while (s_axi_arvalid != '0 && guard < 8) begin
      serve(0, $urandom_range(0, 2), $urandom_range(0, 2), 2'b00, -1, -1, w);
      guard++;
    end
    chk("drained", s_axi_arvalid, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
